// File: rtl/sram16_bridge88.sv
// Bridges core88 byte requests onto a 512K x 16 asynchronous SRAM with programmable wait states.
// Optional one-entry read cache is built when WORD_CACHE_EN is defined.
module sram16_bridge88 #(
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned SRAM_AW  = 19
) (
    input  logic               clock,
    input  logic               locked,
    input  logic               req,
    input  logic [31:0]        address,
    input  logic               wreq,
    input  logic [7:0]         data,
    output logic [7:0]         bus,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_a,
    input  logic [15:0]        sram_di,
    output logic [15:0]        sram_do,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-1:0] a_q, a_d;
    logic               hi_q, hi_d;
    logic               wr_q, wr_d;
    logic [15:0]        do_q, do_d;
    logic [7:0]         bus_q, bus_d;
    logic               ready_q, ready_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic               dq_oe_q, dq_oe_d;

    logic               in_range;
    logic [7:0]         rd_byte;

    assign in_range = (address[31:SRAM_AW+1] == '0);
    assign rd_byte  = hi_q ? sram_di[15:8] : sram_di[7:0];

`ifdef WORD_CACHE_EN
    logic               c_valid_q, c_valid_d;
    logic [SRAM_AW-1:0] c_tag_q, c_tag_d;
    logic [15:0]        c_word_q, c_word_d;
    logic               c_hit;

    assign c_hit = !wreq && c_valid_q && (c_tag_q == address[SRAM_AW:1]);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_d    = hi_q;
        wr_d    = wr_q;
        do_d    = do_q;
        bus_d   = bus_q;
        ready_d = 1'b0;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
        dq_oe_d = dq_oe_q;
`ifdef WORD_CACHE_EN
        c_valid_d = c_valid_q;
        c_tag_d   = c_tag_q;
        c_word_d  = c_word_q;
`endif
        case (state_q)
            StIdle: begin
                if (req) begin
                    wr_d = wreq;
                    hi_d = address[0];
                    if (!in_range) begin
                        // Out-of-window: acknowledge without touching the SRAM.
                        state_d = StDone;
                        if (!wreq) begin
                            bus_d = 8'hFF;
                        end
`ifdef WORD_CACHE_EN
                    end else if (c_hit) begin
                        state_d = StDone;
                        bus_d   = address[0] ? c_word_q[15:8] : c_word_q[7:0];
`endif
                    end else begin
                        state_d = StSetup;
                        a_d     = address[SRAM_AW:1];
                        do_d    = {data, data};
                        ce_n_d  = 1'b0;
                        oe_n_d  = wreq;
                        dq_oe_d = wreq;
                        ub_n_d  = ~address[0];
                        lb_n_d  = address[0];
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CntLoad;
                we_n_d  = ~wr_q;
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    if (!wr_q) begin
                        bus_d = rd_byte;
                    end
`ifdef WORD_CACHE_EN
                    if (!wr_q) begin
                        c_valid_d = 1'b1;
                        c_tag_d   = a_q;
                        c_word_d  = sram_di;
                    end else if (c_valid_q && (c_tag_q == a_q)) begin
                        if (hi_q) begin
                            c_word_d[15:8] = do_q[7:0];
                        end else begin
                            c_word_d[7:0] = do_q[7:0];
                        end
                    end
`endif
                end
            end
            StDone: begin
                // Write data stays driven one cycle past we_n for hold time.
                state_d = StIdle;
                ready_d = 1'b1;
                dq_oe_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!locked) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            hi_q    <= 1'b0;
            wr_q    <= 1'b0;
            do_q    <= 16'h0000;
            bus_q   <= 8'h00;
            ready_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            wr_q    <= wr_d;
            do_q    <= do_d;
            bus_q   <= bus_d;
            ready_q <= ready_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

`ifdef WORD_CACHE_EN
    always_ff @(posedge clock) begin
        if (!locked) begin
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_word_q  <= 16'h0000;
        end else begin
            c_valid_q <= c_valid_d;
            c_tag_q   <= c_tag_d;
            c_word_q  <= c_word_d;
        end
    end
`endif

    assign bus        = bus_q;
    assign ready      = ready_q;
    assign sram_a     = a_q;
    assign sram_do    = do_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram16_bridge88.sv
// Bench for sram16_bridge88: two instances (WAIT_CYC=1 and 4), each with an SRAM model,
// checked against a byte-level memory reference model. Honours WORD_CACHE_EN.
module tb_sram16_bridge88;

    logic        clk = 1'b0;
    logic        locked [2];
    logic        req [2];
    logic [31:0] address [2];
    logic        wreq [2];
    logic [7:0]  data [2];
    logic [7:0]  bus [2];
    logic        ready [2];
    logic [18:0] sram_a [2];
    logic [15:0] sram_di [2];
    logic [15:0] sram_do [2];
    logic        dq_oe [2];
    logic        ce_n [2];
    logic        oe_n [2];
    logic        we_n [2];
    logic        ub_n [2];
    logic        lb_n [2];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_bus [2];
    logic [31:0] last_a [2];
`ifdef WORD_CACHE_EN
    bit          cvalid [2];
    logic [18:0] ctag [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [2048];

        sram16_bridge88 #(
            .WAIT_CYC((g == 0) ? 1 : 4),
            .SRAM_AW (19)
        ) dut (
            .clock     (clk),
            .locked    (locked[g]),
            .req       (req[g]),
            .address   (address[g]),
            .wreq      (wreq[g]),
            .data      (data[g]),
            .bus       (bus[g]),
            .ready     (ready[g]),
            .sram_a    (sram_a[g]),
            .sram_di   (sram_di[g]),
            .sram_do   (sram_do[g]),
            .sram_dq_oe(dq_oe[g]),
            .sram_ce_n (ce_n[g]),
            .sram_oe_n (oe_n[g]),
            .sram_we_n (we_n[g]),
            .sram_ub_n (ub_n[g]),
            .sram_lb_n (lb_n[g])
        );

        initial begin
            for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        end

        always @(posedge clk) begin
            if (!ce_n[g] && !we_n[g]) begin
                if (!lb_n[g]) mem[sram_a[g][10:0]][7:0] <= sram_do[g][7:0];
                if (!ub_n[g]) mem[sram_a[g][10:0]][15:8] <= sram_do[g][15:8];
            end
        end

        // Garbage when the chip is not driving, so mistimed sampling shows up.
        assign sram_di[g] = (ce_n[g] || oe_n[g]) ? 16'hDEAD : mem[sram_a[g][10:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_key(input int sel, input logic [31:0] addr);
        return (sel << 21) | int'(addr[19:0]);
    endfunction

    function automatic logic [7:0] ref_rd(input int sel, input logic [31:0] addr);
        int k = ref_key(sel, addr);
        if (ref_mem.exists(k)) return ref_mem[k];
        return 8'h00;
    endfunction

    // Issue one access, follow it to ready, and compare against the reference model.
    task automatic do_access(input int sel, input logic [31:0] addr, input logic wr,
                             input logic [7:0] d, input bit hold);
        int w, exp_lat, cyc, ce_c, oe_c, we_c, dq_c;
        bit inr, hit, full, got;
        w   = (sel == 0) ? 1 : 4;
        inr = (addr[31:20] == 12'h000);
        hit = 1'b0;
`ifdef WORD_CACHE_EN
        hit = !wr && inr && cvalid[sel] && (ctag[sel] == addr[19:1]);
`endif
        full    = inr && !hit;
        exp_lat = full ? 2 + w : 1;
        if (!wr) exp_bus[sel] = inr ? ref_rd(sel, addr) : 8'hFF;
        address[sel] = addr;
        wreq[sel]    = wr;
        data[sel]    = d;
        req[sel]     = 1'b1;
        cyc = 0; ce_c = 0; oe_c = 0; we_c = 0; dq_c = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("ready_not_early", 32'(ready[sel]), 32'd0);
            if (!ce_n[sel]) begin
                ce_c++;
                check("sram_a", 32'(sram_a[sel]), 32'(addr[19:1]));
                check("lanes", 32'({ub_n[sel], lb_n[sel]}), 32'({~addr[0], addr[0]}));
            end
            if (!oe_n[sel]) oe_c++;
            if (!we_n[sel]) begin
                we_c++;
                check("sram_do", 32'(sram_do[sel]), 32'({d, d}));
            end
            if (dq_oe[sel]) dq_c++;
            if (ready[sel]) begin
                got = 1'b1;
                if (!hold) req[sel] = 1'b0;
            end
        end
        if (!got) req[sel] = 1'b0;
        check("ready_seen", 32'(got), 32'd1);
        check("latency", 32'(cyc - 1), 32'(exp_lat));
        check("bus", 32'(bus[sel]), 32'(exp_bus[sel]));
        check("ce_cycles", 32'(ce_c), full ? 32'(w + 1) : 32'd0);
        check("oe_cycles", 32'(oe_c), (full && !wr) ? 32'(w + 1) : 32'd0);
        check("we_cycles", 32'(we_c), (full && wr) ? 32'(w) : 32'd0);
        check("dq_oe_cycles", 32'(dq_c), (full && wr) ? 32'(w + 2) : 32'd0);
        if (inr && wr) ref_mem[ref_key(sel, addr)] = d;
`ifdef WORD_CACHE_EN
        if (full && !wr) begin
            cvalid[sel] = 1'b1;
            ctag[sel]   = addr[19:1];
        end
`endif
        if (inr) last_a[sel] = addr;
        if (!hold) begin
            @(negedge clk);
            check("ready_one_pulse", 32'(ready[sel]), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input int sel);
        check("rst_ready", 32'(ready[sel]), 32'd0);
        check("rst_bus", 32'(bus[sel]), 32'h00);
        check("rst_strobes", 32'({ce_n[sel], oe_n[sel], we_n[sel], ub_n[sel], lb_n[sel]}),
              32'h1F);
        check("rst_dq_oe", 32'(dq_oe[sel]), 32'd0);
        check("rst_sram_a", 32'(sram_a[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int k;
        for (int s = 0; s < 2; s++) begin
            locked[s] = 1'b0; req[s] = 1'b0; address[s] = '0; wreq[s] = 1'b0;
            data[s] = '0; exp_bus[s] = 8'h00; last_a[s] = '0;
`ifdef WORD_CACHE_EN
            cvalid[s] = 1'b0; ctag[s] = '0;
`endif
        end
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        locked[0] = 1'b1;
        locked[1] = 1'b1;
        @(negedge clk);

        // WAIT_CYC=1: write then read back, lane selection
        do_access(0, 32'h0000_0401, 1'b1, 8'hA5, 1'b0);
        do_access(0, 32'h0000_0401, 1'b0, 8'h00, 1'b0);
        check("read_back_A5", 32'(bus[0]), 32'hA5);
        do_access(0, 32'h0000_0400, 1'b1, 8'h34, 1'b0);
        do_access(0, 32'h0000_0401, 1'b1, 8'h12, 1'b0);
        do_access(0, 32'h0000_0400, 1'b0, 8'h00, 1'b0);
        check("lane_lo_34", 32'(bus[0]), 32'h34);
        do_access(0, 32'h0000_0401, 1'b0, 8'h00, 1'b0);
        check("lane_hi_12", 32'(bus[0]), 32'h12);

        // Window decode and its boundary
        do_access(0, 32'h0010_0000, 1'b0, 8'h00, 1'b0);
        check("oor_read_FF", 32'(bus[0]), 32'hFF);
        do_access(0, 32'h0000_0400, 1'b0, 8'h00, 1'b0);
        do_access(0, 32'h0010_0000, 1'b1, 8'h5A, 1'b0);
        do_access(0, 32'h000F_FFFF, 1'b1, 8'hC3, 1'b0);
        do_access(0, 32'h000F_FFFF, 1'b0, 8'h00, 1'b0);
        check("top_byte_C3", 32'(bus[0]), 32'hC3);

        // WAIT_CYC=4: single read, then back-to-back accesses
        do_access(1, 32'h0000_0123, 1'b1, 8'h9E, 1'b0);
        do_access(1, 32'h0000_0123, 1'b0, 8'h00, 1'b0);
        do_access(1, 32'h0000_0200, 1'b1, 8'h11, 1'b1);
        do_access(1, 32'h0000_0201, 1'b1, 8'h22, 1'b1);
        do_access(1, 32'h0020_0000, 1'b0, 8'h00, 1'b1);
        do_access(1, 32'h0000_0201, 1'b0, 8'h00, 1'b1);
        do_access(1, 32'h0000_0300, 1'b0, 8'h00, 1'b0);

        // Read fills the cache (when built), neighbour hits, write updates the cached byte
        do_access(1, 32'h0000_0600, 1'b0, 8'h00, 1'b0);
        do_access(1, 32'h0000_0601, 1'b0, 8'h00, 1'b0);
        do_access(1, 32'h0000_0601, 1'b1, 8'h77, 1'b0);
        do_access(1, 32'h0000_0601, 1'b0, 8'h00, 1'b0);
        check("cached_77", 32'(bus[1]), 32'h77);

        // Reset during the ACCESS phase of a write
        address[1] = 32'h0000_07F0; wreq[1] = 1'b1; data[1] = 8'h3C; req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_we_low", 32'(we_n[1]), 32'd0);
        locked[1] = 1'b0;
        req[1]    = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(we_n[1]), 32'd1);
        check("abort_ce_n", 32'(ce_n[1]), 32'd1);
        check("abort_dq_oe", 32'(dq_oe[1]), 32'd0);
        check("abort_ready", 32'(ready[1]), 32'd0);
        check("abort_bus", 32'(bus[1]), 32'h00);
        ref_mem[ref_key(1, 32'h0000_07F0)] = 8'h3C;
        exp_bus[1] = 8'h00;
`ifdef WORD_CACHE_EN
        cvalid[1] = 1'b0;
`endif
        locked[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 32'({ready[1], ce_n[1]}), 32'b01);
        end
        do_access(1, 32'h0000_07F0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 40; r++) begin
                k = $urandom_range(0, 7);
                if (k == 0) a = {12'($urandom_range(1, 4095)), 20'($urandom_range(0, 2047))};
                else if (k < 3) a = last_a[s] ^ 32'h1;
                else a = 32'($urandom_range(0, 2047));
                do_access(s, a, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
                          (r != 39) && ($urandom_range(0, 3) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram16_bridge88.md
Name: sram16_bridge88

Overview:
- Memory-side stage directly downstream of core88: converts the core's byte-wide request (address, data, wreq) into accesses on an external 512K x 16 asynchronous SRAM.
- Provides a req/ready handshake with a programmable wait-state count.
- Decodes the 1 MB real-mode window; out-of-range accesses complete without an SRAM cycle.

Parameters:
- WAIT_CYC, 1, number of ACCESS-state cycles per SRAM access; legal range 1..15.
- SRAM_AW, 19, SRAM word-address width (2^19 words x 16 bits = 1 MB).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- locked  in  1  synchronous active-low reset; 0 = reset, 1 = run.
- req  in  1  core access strobe; address, data and wreq are held stable from req high until ready.
- address  in  32  byte address from core.
- wreq  in  1  1 = write, 0 = read; qualified by req.
- data  in  8  write data from core.
- bus  out  8  read data to core.
- ready  out  1  one-cycle completion pulse.
- sram_a  out  SRAM_AW  word address = address[SRAM_AW:1].
- sram_di  in  16  SRAM read data.
- sram_do  out  16  SRAM write data = {data, data}.
- sram_dq_oe  out  1  top-level tristate enable for sram_do.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_ub_n  out  1  upper byte lane, selected when address[0]=1.
- sram_lb_n  out  1  lower byte lane, selected when address[0]=0.

Behaviour:
- Reset (locked=0 at a clock edge; takes priority and aborts any access in progress):
  - state=IDLE; ready=0; bus=8'h00.
  - sram_ce_n, oe_n, we_n, ub_n and lb_n all =1; sram_dq_oe=0; sram_a=0.
  - The aborted access is never acknowledged.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req=0: stay in IDLE.
  - req=1 and address[31:20]!=0 (out of range): go to DONE. No SRAM strobe. A read returns bus=8'hFF; a write is dropped.
  - req=1 and in range: go to SETUP. Latch sram_a and the byte lane; drive ce_n=0.
    - Read: oe_n=0.
    - Write: dq_oe=1.
- SETUP: one cycle, then ACCESS; the wait counter is loaded with WAIT_CYC-1.
  - Write: we_n=0 for the whole of ACCESS.
- ACCESS:
  - Counter >0: decrement and stay.
  - Counter =0: go to DONE.
  - Read: on the ACCESS->DONE edge, bus <= address[0] ? sram_di[15:8] : sram_di[7:0].
  - On the same edge: we_n=1, oe_n=1, ce_n=1, byte lanes=1.
- dq_oe is deasserted one cycle after we_n, on the DONE->IDLE edge (data hold).
- DONE: ready=1 for exactly one cycle, then IDLE.
- Latency: req sampled at edge N gives ready high after edge N+2+WAIT_CYC (out-of-range: after edge N+1).
- bus holds the last read value (or FF) until the next completed read; writes do not change bus.
- req is sampled only in IDLE. If req is still high in the IDLE cycle after DONE, a new access starts (back-to-back). The core drops req in the cycle ready is high.
- Changes to address, data or wreq while busy are ignored.

Optional Feature:
- Macro: WORD_CACHE_EN.
- Defined:
  - One-entry read cache: 16-bit word, word tag and valid flag.
  - Every completed in-range SRAM read fills the entry (tag = address[SRAM_AW:1], valid=1).
  - A read in IDLE whose tag matches while valid is a hit: go directly to DONE with no SRAM strobes; bus gets the selected byte; ready after edge N+1.
  - A write to the cached word updates the matching byte lane in the cache; the write itself is still performed to SRAM.
  - Reset clears valid. Out-of-range accesses do not affect the cache.
- Undefined: no cache logic; every in-range read uses the full SRAM cycle.

Test Plan:
- Reset mid-access: locked=0 during ACCESS of a write.
  - Next cycle: we_n=1, ce_n=1, dq_oe=0, ready=0, bus=00.
  - After locked=1: idle until req.
- Write then read, WAIT_CYC=1:
  - Write 8'hA5 to 0x00401.
  - Expect sram_a=0x00200, ub_n=0, lb_n=1, we_n=0 for 1 cycle, sram_do=16'hA5A5, ready 3 cycles after req.
  - Read 0x00401 with sram_di=16'hA5xx: bus=A5 with ready.
- Lane select:
  - Read 0x00400 with sram_di=16'h1234: bus=34, lb_n=0.
  - Read 0x00401: bus=12.
- Out of range:
  - Read 0x00100000: no ce_n pulse, ready after 1 cycle, bus=FF.
  - Write 0x00100000: no strobes, ready after 1 cycle, bus unchanged.
- Wait states, WAIT_CYC=4: read shows oe_n=0 for 5 cycles and ready 6 cycles after req; back-to-back reqs are acknowledged in order.
- WORD_CACHE_EN defined:
  - Read 0x00400 (miss, full cycle) fills the cache; next read 0x00401 gets ready 1 cycle after req with no ce_n pulse.
  - Write 8'h77 to 0x00401, then read 0x00401: bus=77 via hit.
